// File: rtl/noc_pkg.sv
// noc_pkg: shared flit type, port select and turn encodings for the router output port
package noc_pkg;
  localparam int NUM_PORTS = 5;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } flit_t;
  localparam logic [2:0] SEL_N = 3'd0;
  localparam logic [2:0] SEL_S = 3'd1;
  localparam logic [2:0] SEL_E = 3'd2;
  localparam logic [2:0] SEL_W = 3'd3;
  localparam logic [2:0] SEL_L = 3'd4;
  localparam logic [4:0] TURN_N = 5'b10000;
  localparam logic [4:0] TURN_S = 5'b01000;
  localparam logic [4:0] TURN_E = 5'b00100;
  localparam logic [4:0] TURN_W = 5'b00010;
  localparam logic [4:0] TURN_L = 5'b00001;
endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: power-of-two output queue with wrapping pointers and an occupancy counter
module noc_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  // a pop on the same edge frees the slot, so a push into a full queue is legal then
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/noc_output_port.sv
// noc_output_port: source select into an output queue, rotating arbitration turn, credit-gated link drain
module noc_output_port import noc_pkg::*; #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] N_data_i,
  input  logic [DATA_W-1:0] S_data_i,
  input  logic [DATA_W-1:0] E_data_i,
  input  logic [DATA_W-1:0] W_data_i,
  input  logic [DATA_W-1:0] L_data_i,
  input  logic [2:0]        port_select,
  input  logic              port_enable,
  output logic              port_full,
  output logic [4:0]        turn,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              credit_return_i,
  output logic              err_o
);
  localparam int CW = $clog2(CREDITS+1);
  logic [CW-1:0] credit_cnt;
  logic [DATA_W-1:0] sel_data, head;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic sel_ok, push, send, full, empty, credit_ovf;
  always_comb begin
    sel_data = port_select == SEL_N ? N_data_i :
               port_select == SEL_S ? S_data_i :
               port_select == SEL_E ? E_data_i :
               port_select == SEL_W ? W_data_i : L_data_i;
  end
  assign sel_ok     = port_select <= SEL_L;
  assign port_full  = count == $bits(count)'(DEPTH);
  assign push       = port_enable && sel_ok && !full;
  assign send       = !empty && credit_cnt != '0;
  assign credit_ovf = credit_return_i && !send && credit_cnt == CW'(CREDITS);
  noc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(send), .wdata(sel_data),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      turn        <= TURN_N;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      credit_cnt  <= CW'(CREDITS);
      err_o       <= 1'b0;
    end else begin
      turn        <= {turn[0], turn[4:1]};
      out_valid_o <= send;
      if (send) out_data_o <= head;
      if (!credit_ovf) credit_cnt <= credit_cnt + CW'(credit_return_i) - CW'(send);
      err_o       <= err_o | credit_ovf | (port_enable && (!sel_ok || full));
    end
  end
endmodule

// File: tb/tb_noc_output_port.sv
// tb_noc_output_port: directed test-plan walk plus randomized segments against a queue-based model
module tb_noc_output_port;
  localparam int DEPTH = 4, CREDITS = 4;
  logic clk = 0, rst;
  logic [7:0] N_data_i, S_data_i, E_data_i, W_data_i, L_data_i, out_data_o;
  logic [2:0] port_select;
  logic port_enable, port_full, out_valid_o, credit_return_i, err_o;
  logic [4:0] turn;
  int vectors = 0, miscompares = 0;
  logic [7:0] q[$];
  int cred, mturn;
  logic mov, merr;
  logic [7:0] mod;
  noc_output_port #(.DATA_W(8), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst), .N_data_i(N_data_i), .S_data_i(S_data_i), .E_data_i(E_data_i),
    .W_data_i(W_data_i), .L_data_i(L_data_i), .port_select(port_select), .port_enable(port_enable),
    .port_full(port_full), .turn(turn), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .credit_return_i(credit_return_i), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic cycle(input bit en, input bit [2:0] sel, input bit [7:0] d, input bit ret, input bit r);
    logic [7:0] src [5];
    logic [4:0] t1 = 5'b10000;
    bit send, full;
    for (int i = 0; i < 5; i++) src[i] = 8'($urandom);
    if (sel < 5) src[sel] = d;
    {N_data_i, S_data_i, E_data_i, W_data_i, L_data_i} = {src[0], src[1], src[2], src[3], src[4]};
    port_select = sel; port_enable = en; credit_return_i = ret; rst = r;
    if (r) begin
      q.delete(); cred = CREDITS; mturn = 0; mov = 0; mod = 0; merr = 0;
    end else begin
      full = q.size() == DEPTH;
      send = q.size() > 0 && cred > 0;
      mov = send;
      if (send) mod = q.pop_front();
      if (en && sel < 5 && !full) q.push_back(src[sel]);
      if (en && (sel > 4 || full)) merr = 1;
      if (ret && !send && cred == CREDITS) merr = 1;
      else cred = cred + int'(ret) - int'(send);
      mturn = (mturn + 1) % 5;
    end
    @(negedge clk);
    chk("turn", 32'(turn), 32'(t1 >> mturn));
    chk("port_full", 32'(port_full), 32'(q.size() == DEPTH));
    chk("out_valid", 32'(out_valid_o), 32'(mov));
    chk("out_data", 32'(out_data_o), 32'(mod));
    chk("err", 32'(err_o), 32'(merr));
  endtask
  initial begin
    int enp, retp, badp;
    bit [2:0] s;
    cycle(0, 0, 0, 0, 1);
    repeat (10) cycle(0, 3'($urandom_range(0, 7)), 0, 0, 0);
    cycle(1, 3'd2, 8'h23, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 3'($urandom_range(0, 4)), 8'(8'h10 + i), 0, 0);
    cycle(1, 3'd0, 8'h99, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    repeat (2) begin
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0);
    end
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) cycle(1, 3'($urandom_range(0, 4)), 8'(8'h40 + i), i > 0 && cred < CREDITS, 0);
    cycle(1, 3'd1, 8'h77, 0, 0);
    cycle(1, 3'd2, 8'h78, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 3'd5, 8'h00, 0, 0);
    for (int g = 0; g < 40; g++) begin
      enp = $urandom_range(10, 100); retp = $urandom_range(0, 100); badp = $urandom_range(0, 10);
      if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0, 1);
      for (int c = 0; c < 50; c++) begin
        s = ($urandom_range(0, 99) < badp) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        cycle($urandom_range(0, 99) < enp, s, 8'($urandom),
              $urandom_range(0, 99) < retp && ($urandom_range(0, 19) == 0 || cred < CREDITS), 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
